// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Latency: n/a (types, constants and a pure decode function).
// Backpressure: n/a.
package keypad_pkg;

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HELD
    } ScanState;

    // Key code indexed by {row, col}; nibble 0 is row 0 / column 0.
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E 0 F D
    localparam logic [15:0][3:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    typedef struct packed {
        logic       single;  // exactly one row pulled low
        logic       idle;    // no row pulled low
        logic [1:0] idx;     // index of the low row when single
    } row_dec_t;

    // Classify a synchronized active-low row sample.
    function automatic row_dec_t decode_row(input logic [3:0] rows);
        row_dec_t d;
        d.idle   = (rows == 4'b1111);
        d.single = 1'b1;
        d.idx    = 2'd0;
        case (rows)
            4'b1110: d.idx = 2'd0;
            4'b1101: d.idx = 2'd1;
            4'b1011: d.idx = 2'd2;
            4'b0111: d.idx = 2'd3;
            default: d.single = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer bringing the asynchronous keypad rows into CLK.
// Latency: 2 cycles from row change to synced output.
// Backpressure: none; samples every cycle. Resets to all-ones (no key).
module keypad_sync (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] raw,
    output logic [3:0] synced
);

    logic [3:0] meta;

    // Two-stage capture; reset value matches the pulled-up idle rows.
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta   <= 4'b1111;
            synced <= 4'b1111;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 keypad and emits one debounced enable strobe + digit per press.
// Latency: (DEBOUNCE_SCANS-1)*SCAN_DIV+1 cycles from first detecting tick to enable.
// Backpressure: none; the downstream block must accept each one-cycle strobe.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] digit,
    output logic       enable,
    output logic       keyHeld
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_SCANS);

    logic [3:0]    row_s;
    logic [TW-1:0] tcnt;
    logic          tick;
    ScanState      state, state_n;
    logic [1:0]    c, c_n;
    logic [3:0]    code, code_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [CW-1:0] rel, rel_n, rel_inc;
    logic [3:0]    digit_n;
    logic          enable_n;
    logic          key_held_n;
    row_dec_t      dec;
    logic [3:0]    sample_code;

    keypad_sync u_sync (
        .CLK    (CLK),
        .RST    (RST),
        .raw    (row),
        .synced (row_s)
    );

    assign tick        = (tcnt == TICK_LAST);
    assign col         = ~(4'b0001 << c);
    assign dec         = decode_row(row_s);
    assign sample_code = KEY_MAP[{dec.idx, c}];
    assign cnt_inc     = cnt + CW'(1);
    assign rel_inc     = rel + CW'(1);

    // Free-running sample-period counter; tick marks its last cycle.
    always_ff @(posedge CLK) begin
        if (RST || tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // FSM and output registers; reset overrides any acceptance in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_SCAN;
            c       <= 2'd0;
            code    <= 4'd0;
            cnt     <= '0;
            rel     <= '0;
            digit   <= 4'd0;
            enable  <= 1'b0;
            keyHeld <= 1'b0;
        end else begin
            state   <= state_n;
            c       <= c_n;
            code    <= code_n;
            cnt     <= cnt_n;
            rel     <= rel_n;
            digit   <= digit_n;
            enable  <= enable_n;
            keyHeld <= key_held_n;
        end
    end

    // Next-state: detect, debounce press, then debounce release before rescanning.
    always_comb begin
        state_n    = state;
        c_n        = c;
        code_n     = code;
        cnt_n      = cnt;
        rel_n      = rel;
        digit_n    = digit;
        enable_n   = 1'b0;
        key_held_n = keyHeld;
        if (tick) begin
            case (state)
                S_SCAN: begin
                    if (dec.single) begin
                        code_n  = sample_code;
                        cnt_n   = CW'(1);
                        state_n = S_DEBOUNCE;
                    end else begin
                        c_n = c + 2'd1;
                    end
                end
                S_DEBOUNCE: begin
                    if (dec.single && (sample_code == code)) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            digit_n    = code;
                            enable_n   = 1'b1;
                            key_held_n = 1'b1;
                            rel_n      = '0;
                            state_n    = S_HELD;
                        end
                    end else begin
                        state_n = S_SCAN;
                        c_n     = c + 2'd1;
                    end
                end
                S_HELD: begin
                    // Any activity on the frozen column, including a second
                    // key, restarts the release count and is otherwise ignored.
                    if (dec.idle) begin
                        rel_n = rel_inc;
                        if (rel_inc == CNT_DONE) begin
                            key_held_n = 1'b0;
                            state_n    = S_SCAN;
                            c_n        = c + 2'd1;
                        end
                    end else begin
                        rel_n = '0;
                    end
                end
                default: state_n = S_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix.
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_scanner;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  digit;
    logic        enable;
    logic        keyHeld;

    logic [15:0] keys = '0;   // pressed keys, index row*4+col
    int          tests = 0;
    int          fails = 0;
    int          en_cnt = 0;
    int          cyc = 0;
    int          en_base;
    logic [3:0]  last_digit = 4'd0;
    logic [3:0]  e;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .row     (row),
        .col     (col),
        .digit   (digit),
        .enable  (enable),
        .keyHeld (keyHeld)
    );

    always #5 CLK = ~CLK;

    // Keypad matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int i = 0; i < 16; i++) begin
            if (keys[i] && !col[i % 4]) row[i / 4] = 1'b0;
        end
    end

    // Strobe monitor on the falling edge.
    always @(negedge CLK) begin
        if (enable === 1'b1) begin
            en_cnt     <= en_cnt + 1;
            last_digit <= digit;
        end
    end

    // Reference phase of the sample-period counter.
    always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic wait_col(input logic [3:0] v);
        logic [3:0] prev;
        bit found;
        prev  = col;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            step();
            if (col == v && prev != v) found = 1'b1;
            prev = col;
        end
        chk("wait_col", int'(found), 1);
    endtask

    initial begin
        // Reset state.
        RST  = 1'b1;
        keys = '0;
        repeat (3) step();
        chk("rst_col", int'(col), 'hE);
        chk("rst_digit", int'(digit), 0);
        chk("rst_enable", int'(enable), 0);
        chk("rst_held", int'(keyHeld), 0);
        RST = 1'b0;

        // Idle scan: each column driven for 4 cycles, rotating.
        for (int k = 0; k < 20; k++) begin
            e = 4'hF ^ (4'h1 << ((k / 4) % 4));
            chk("idle_col", int'(col), int'(e));
            step();
        end
        chk("idle_no_strobe", en_cnt, 0);

        // Bounce on key 1: one matching sample, then gone.
        wait_col(4'b1110);
        keys[0] = 1'b1;
        repeat (4) step();
        chk("bounce_frozen", int'(col), 'hE);
        keys[0] = 1'b0;
        repeat (3) step();
        chk("bounce_frozen2", int'(col), 'hE);
        step();
        chk("bounce_resume", int'(col), 'hD);
        chk("bounce_no_strobe", en_cnt, 0);

        // Long hold of key 5 (row 1, column 1).
        keys[5] = 1'b1;
        repeat (200) step();
        chk("k5_strobes", en_cnt, 1);
        chk("k5_digit", int'(last_digit), 5);
        chk("k5_held", int'(keyHeld), 1);
        chk("k5_col_frozen", int'(col), 'hD);

        // Release aligned to the start of a sample period.
        for (int i = 0; i < 4 && (cyc % 4) != 0; i++) step();
        keys = '0;
        repeat (11) step();
        chk("rel_held_still", int'(keyHeld), 1);
        step();
        chk("rel_held_fall", int'(keyHeld), 0);
        chk("rel_col_adv", int'(col), 'hB);

        // Key 0 (row 3, column 1) pressed as column 1 comes up.
        wait_col(4'b1101);
        keys[13] = 1'b1;
        repeat (11) step();
        chk("k0_pre_enable", int'(enable), 0);
        chk("k0_pre_digit", int'(digit), 5);
        step();
        chk("k0_enable", int'(enable), 1);
        chk("k0_digit", int'(digit), 0);
        chk("k0_held", int'(keyHeld), 1);
        step();
        chk("k0_enable_one", int'(enable), 0);
        keys = '0;
        for (int i = 0; i < 40 && keyHeld; i++) step();
        chk("k0_release", int'(keyHeld), 0);
        chk("k0_strobes", en_cnt, 2);

        // Keys 2 and 5 together on column 1: ambiguous, ignored.
        en_base = en_cnt;
        keys[1] = 1'b1;
        keys[5] = 1'b1;
        repeat (100) step();
        chk("dual_no_strobe", en_cnt, en_base);
        chk("dual_digit", int'(digit), 0);
        chk("dual_held", int'(keyHeld), 0);
        keys = '0;

        // Reset while debouncing key 9 (row 2, column 2).
        wait_col(4'b1011);
        keys[10] = 1'b1;
        repeat (5) step();
        chk("k9_frozen", int'(col), 'hB);
        RST = 1'b1;
        step();
        chk("k9_rst_col", int'(col), 'hE);
        chk("k9_rst_held", int'(keyHeld), 0);
        chk("k9_rst_enable", int'(enable), 0);
        chk("k9_rst_digit", int'(digit), 0);
        RST  = 1'b0;
        keys = '0;
        en_base = en_cnt;
        repeat (60) step();
        chk("k9_no_strobe", en_cnt, en_base);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
